cereal_arbiter: RTL and testbench

- Shares the single `cereal` serial transmitter between two byte sources:
  - the live echo path (bytes just received on `serialIn`);
  - the playback path (bytes read back from the message RAM on a write-button press).
- Accepts one byte at a time per requester through a valid/ack handshake and drives `cereal`'s `data`/`start`.
- Counts `cereal`'s bit `pulse` to find the end of each frame, then inserts a programmable idle gap.
- Sits between the tweetboard top-level control and the `cereal` instance, replacing the direct `data`/`start` drive.

---
 rtl/cereal_arbiter.sv | 119 +++++++++++
 tb/tb_cereal_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cereal_arbiter.sv
// Shares one cereal serial transmitter between the echo and playback byte sources.
// Latency: a request in IDLE raises tx_start, ack and grant on the next sysclk edge.
// Backpressure: each requester holds valid/data until its ack; requests are ignored in SEND and GAP.
// Build option: define CEREAL_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: echo has fixed priority).
module cereal_arbiter #(
  parameter int FRAME_BITS = 10,
  parameter int GAP_PULSES = 2
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  output logic       echo_ack,
  output logic       echo_done,
  input  logic       play_valid,
  input  logic [7:0] play_data,
  output logic       play_ack,
  output logic       play_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_pulse,
  output logic       busy,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

`ifdef CEREAL_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [3:0] FRAME_END = 4'(FRAME_BITS);
  localparam logic [3:0] GAP_END   = 4'(GAP_PULSES);

  state_t     state;
  logic [3:0] bit_cnt;
  logic [3:0] cnt_inc;
  logic       last_grant_play;  // 1 = playback owned the last completed frame
  logic       pick_play;

  assign cnt_inc = bit_cnt + 4'd1;

  // Winner select: playback wins when alone, or on a tie when round-robin says it is its turn
  assign pick_play = play_valid && (!echo_valid || (RR_EN && !last_grant_play));

  // Arbitration FSM with registered transmitter drive and handshake pulses
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state           <= IDLE;
      bit_cnt         <= 4'd0;
      last_grant_play <= 1'b1;
      tx_data         <= 8'd0;
      tx_start        <= 1'b0;
      busy            <= 1'b0;
      grant           <= 2'b00;
      echo_ack        <= 1'b0;
      play_ack        <= 1'b0;
      echo_done       <= 1'b0;
      play_done       <= 1'b0;
    end else begin
      echo_ack  <= 1'b0;
      play_ack  <= 1'b0;
      echo_done <= 1'b0;
      play_done <= 1'b0;
      case (state)
        IDLE: begin
          // tx_pulse is deliberately ignored here; the counter restarts with each grant
          if (echo_valid || play_valid) begin
            tx_data  <= pick_play ? play_data : echo_data;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            grant    <= pick_play ? 2'b10 : 2'b01;
            echo_ack <= !pick_play;
            play_ack <= pick_play;
            bit_cnt  <= 4'd0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_pulse) begin
            if (cnt_inc == FRAME_END) begin
              tx_start        <= 1'b0;
              echo_done       <= grant[0];
              play_done       <= grant[1];
              bit_cnt         <= 4'd0;
              last_grant_play <= grant[1];
              if (GAP_PULSES == 0) begin
                grant <= 2'b00;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= GAP;
              end
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
        end
        GAP: begin
          // tx_data keeps the last byte; grant stays with the owner until the gap expires
          if (tx_pulse) begin
            if (cnt_inc == GAP_END) begin
              grant   <= 2'b00;
              busy    <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= IDLE;
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cereal_arbiter.sv
module tb_cereal_arbiter;

  logic       sysclk;
  logic       reset_n;
  logic       echo_valid, play_valid;
  logic [7:0] echo_data, play_data;
  logic       echo_ack, echo_done, play_ack, play_done;
  logic [7:0] tx_data;
  logic       tx_start, busy;
  logic [1:0] grant;
  logic       tx_pulse, tbl_pulse, gen_pulse, pulse_en;

  // second instance with no idle gap
  logic       z_echo_valid, z_play_valid;
  logic [7:0] z_echo_data, z_play_data;
  logic       z_echo_ack, z_echo_done, z_play_ack, z_play_done;
  logic [7:0] z_tx_data;
  logic       z_tx_start, z_busy;
  logic [1:0] z_grant;

  int n_checks = 0;
  int n_fail   = 0;

  assign tx_pulse = tbl_pulse | gen_pulse;

  cereal_arbiter #(.FRAME_BITS(10), .GAP_PULSES(2)) u_dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .echo_valid(echo_valid), .echo_data(echo_data), .echo_ack(echo_ack), .echo_done(echo_done),
    .play_valid(play_valid), .play_data(play_data), .play_ack(play_ack), .play_done(play_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_pulse(tx_pulse), .busy(busy), .grant(grant)
  );

  cereal_arbiter #(.FRAME_BITS(10), .GAP_PULSES(0)) u_dut_nogap (
    .sysclk(sysclk), .reset_n(reset_n),
    .echo_valid(z_echo_valid), .echo_data(z_echo_data), .echo_ack(z_echo_ack), .echo_done(z_echo_done),
    .play_valid(z_play_valid), .play_data(z_play_data), .play_ack(z_play_ack), .play_done(z_play_done),
    .tx_data(z_tx_data), .tx_start(z_tx_start), .tx_pulse(gen_pulse), .busy(z_busy), .grant(z_grant)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bit-time pulse generator: one cycle high every third cycle while enabled
  initial begin
    int ph;
    ph = 0;
    gen_pulse = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
      gen_pulse = pulse_en && (ph == 2);
    end
  end

  // scoreboard: expected {grant, tx_data} per accepted byte
  logic [9:0] sb_q[$];
  int eack_cnt = 0, pack_cnt = 0, done_cnt = 0;
  int cyc = 0, busy_fall_cyc = -1, pack_cyc = -1;
  logic prev_busy = 1'b0;

  always @(negedge sysclk) begin
    cyc++;
    if (echo_ack === 1'b1 || play_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", {22'd0, grant, tx_data}, 32'hFFFF);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        check("sb_grant_data", {22'd0, grant, tx_data}, {22'd0, e});
      end
    end
    if (echo_ack === 1'b1) eack_cnt++;
    if (play_ack === 1'b1) begin pack_cnt++; pack_cyc = cyc; end
    if (echo_done === 1'b1 || play_done === 1'b1) done_cnt++;
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = busy;
  end

  typedef struct {
    logic        rst_n;
    logic        ev;
    logic [7:0]  ed;
    logic        pv;
    logic [7:0]  pd;
    logic        p;
    logic [15:0] exp;  // {tx_start, busy, grant, echo_ack, echo_done, play_ack, play_done, tx_data}
  } row_t;

  function automatic logic [15:0] ex(input logic st, input logic bz, input logic [1:0] g,
                                      input logic ea, input logic ed, input logic pa,
                                      input logic pd, input logic [7:0] d);
    return {st, bz, g, ea, ed, pa, pd, d};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; echo_valid = 1'b0; play_valid = 1'b0; tbl_pulse = 1'b0;
    repeat (3) @(negedge sysclk);
    reset_n = 1'b1;
  endtask

  initial begin
    row_t tbl[20];
    int   t0;
    int   np;

    reset_n = 1'b0; echo_valid = 1'b0; play_valid = 1'b0; echo_data = 8'h00; play_data = 8'h00;
    tbl_pulse = 1'b0; pulse_en = 1'b0;
    z_echo_valid = 1'b0; z_echo_data = 8'h00; z_play_valid = 1'b0; z_play_data = 8'h00;

    // --- table: reset with both valids high, then one echo frame 0x41 cycle by cycle
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 8'h41, 1'b1, 8'h69, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 8'h41, 1'b1, 8'h69, 1'b0, ex(1, 1, 2'b01, 1, 0, 0, 0, 8'h41)};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, ex(1, 1, 2'b01, 0, 0, 0, 0, 8'h41)};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ex(1, 1, 2'b01, 0, 0, 0, 0, 8'h41)};
    for (int i = 6; i < 14; i++)
      tbl[i] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, ex(1, 1, 2'b01, 0, 0, 0, 0, 8'h41)};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, ex(0, 1, 2'b01, 0, 1, 0, 0, 8'h41)};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, ex(0, 1, 2'b01, 0, 0, 0, 0, 8'h41)};
    tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, ex(0, 1, 2'b01, 0, 0, 0, 0, 8'h41)};
    tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, ex(0, 0, 2'b00, 0, 0, 0, 0, 8'h41)};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, ex(0, 0, 2'b00, 0, 0, 0, 0, 8'h41)};
    tbl[19] = '{1'b1, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1, ex(1, 1, 2'b01, 1, 0, 0, 0, 8'h42)};

    @(negedge sysclk);
    for (int i = 0; i < 20; i++) begin
      reset_n = tbl[i].rst_n; echo_valid = tbl[i].ev; echo_data = tbl[i].ed;
      play_valid = tbl[i].pv; play_data = tbl[i].pd; tbl_pulse = tbl[i].p;
      if (tbl[i].exp[11] || tbl[i].exp[9]) sb_q.push_back({tbl[i].exp[13:12], tbl[i].exp[7:0]});
      @(posedge sysclk);
      @(negedge sysclk);
      check($sformatf("table_row%0d", i),
            {16'd0, tx_start, busy, grant, echo_ack, echo_done, play_ack, play_done, tx_data},
            {16'd0, tbl[i].exp});
    end

    // --- both requesters held continuously for three frames
    do_reset();
    pulse_en = 1'b1;
`ifdef CEREAL_ARB_ROUND_ROBIN_EN
    sb_q.push_back({2'b01, 8'h48}); sb_q.push_back({2'b10, 8'h69}); sb_q.push_back({2'b01, 8'h48});
`else
    sb_q.push_back({2'b01, 8'h48}); sb_q.push_back({2'b01, 8'h48}); sb_q.push_back({2'b01, 8'h48});
`endif
    begin
      int d0, e0, p0;
      d0 = done_cnt; e0 = eack_cnt; p0 = pack_cnt;
      echo_valid = 1'b1; echo_data = 8'h48; play_valid = 1'b1; play_data = 8'h69;
      for (int i = 0; i < 3000 && done_cnt < d0 + 3; i++) @(negedge sysclk);
      echo_valid = 1'b0; play_valid = 1'b0;
      check("both_three_frames_done", done_cnt - d0, 3);
      for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge sysclk);
      check("both_idle_after", busy, 0);
`ifdef CEREAL_ARB_ROUND_ROBIN_EN
      check("both_play_acks", pack_cnt - p0, 1);
      check("both_echo_acks", eack_cnt - e0, 2);
`else
      check("both_play_acks", pack_cnt - p0, 0);
      check("both_echo_acks", eack_cnt - e0, 3);
`endif
    end

    // --- playback request arriving during an echo frame waits for the gap
    sb_q.push_back({2'b01, 8'h41});
    echo_valid = 1'b1; echo_data = 8'h41;
    for (int i = 0; i < 200 && echo_ack !== 1'b1; i++) @(negedge sysclk);
    check("late_play_echo_ack", echo_ack, 1);
    echo_valid = 1'b0;
    repeat (4) @(negedge sysclk);
    sb_q.push_back({2'b10, 8'h33});
    t0 = pack_cnt;
    play_valid = 1'b1; play_data = 8'h33;
    for (int i = 0; i < 500 && play_ack !== 1'b1; i++) @(negedge sysclk);
    check("late_play_ack_seen", play_ack, 1);
    play_valid = 1'b0;
    @(negedge sysclk);
    check("late_play_ack_count", pack_cnt - t0, 1);
    check("late_play_ack_after_gap", pack_cyc - busy_fall_cyc, 1);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge sysclk);
    check("late_play_idle", busy, 0);

    // --- reset after the 5th pulse of a frame aborts it silently
    sb_q.push_back({2'b01, 8'h5A});
    echo_valid = 1'b1; echo_data = 8'h5A;
    for (int i = 0; i < 200 && echo_ack !== 1'b1; i++) @(negedge sysclk);
    check("abort_ack", echo_ack, 1);
    echo_valid = 1'b0;
    np = 0;
    for (int i = 0; i < 200 && np < 5; i++) begin
      @(negedge sysclk);
      if (tx_pulse === 1'b1) np++;
    end
    @(negedge sysclk);
    check("abort_start_before", tx_start, 1);
    t0 = done_cnt;
    reset_n = 1'b0;
    @(negedge sysclk);
    check("abort_outputs", {27'd0, tx_start, busy, grant, echo_done}, 0);
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (3) @(negedge sysclk);
    check("abort_no_done", done_cnt - t0, 0);
    sb_q.push_back({2'b01, 8'h66});
    echo_valid = 1'b1; echo_data = 8'h66;
    for (int i = 0; i < 200 && echo_ack !== 1'b1; i++) @(negedge sysclk);
    echo_valid = 1'b0;
    for (int i = 0; i < 500 && done_cnt == t0; i++) @(negedge sysclk);
    check("abort_fresh_done", done_cnt - t0, 1);

    // --- zero gap: next frame starts one cycle after done
    z_echo_valid = 1'b1; z_echo_data = 8'h11;
    for (int i = 0; i < 500 && z_echo_done !== 1'b1; i++) @(negedge sysclk);
    check("nogap_done", z_echo_done, 1);
    check("nogap_start_low", {z_tx_start, z_busy}, 2'b00);
    @(negedge sysclk);
    check("nogap_restart", {z_tx_start, z_echo_ack, z_grant}, 4'b1101);
    z_echo_valid = 1'b0;
    repeat (2) @(negedge sysclk);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
